// File: rtl/alu_issue_writeback_if.sv
// Instruction handshake between decode and the alu issue/write-back stage.
//   instr_valid/instr_ready : valid/ready handshake, transfer on the posedge where both are high
//   instr_opcode            : operation
//   instr_rd/rs1/rs2        : destination and source register indices
//   instr_imm               : immediate (ADDI/ANDI only)
// master = decode side, slave = issue stage.
interface alu_issue_writeback_if #(
  parameter int OPCODE_SIZE = 5,
  parameter int REG_ADDR    = 3,
  parameter int IMM_SIZE    = 8
);
  logic                   instr_valid;
  logic                   instr_ready;
  logic [OPCODE_SIZE-1:0] instr_opcode;
  logic [REG_ADDR-1:0]    instr_rd;
  logic [REG_ADDR-1:0]    instr_rs1;
  logic [REG_ADDR-1:0]    instr_rs2;
  logic [IMM_SIZE-1:0]    instr_imm;

  modport master (
    output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_writeback.sv
// Non-pipelined issue / write-back stage wrapped around a registered alu.
// One instruction every 3 cycles: IDLE (accept) -> ISSUE (alu_enable) -> WB (retire).
// Ports:
//   clock, reset          : single clock, asynchronous active-high reset
//   instr                 : decode handshake (slave modport)
//   alu_opcode/input1/2   : registered operands to the alu, frozen at acceptance
//   alu_enable            : high for exactly the ISSUE cycle
//   alu_out               : registered alu result, valid during WB
//   wb_valid/addr/data    : one-cycle retire pulse with destination and result
//   retired_count         : retired instructions, wraps silently
//   dbg_addr/dbg_data     : combinational register-file peek, r0 reads 0
module alu_issue_writeback #(
  parameter int WORD_SIZE   = 16,
  parameter int OPCODE_SIZE = 5,
  parameter int IMM_SIZE    = 8,
  parameter int NUM_REGS    = 8,
  parameter int REG_ADDR    = 3,
  parameter logic [OPCODE_SIZE-1:0] OP_ADDI = 'd10,
  parameter logic [OPCODE_SIZE-1:0] OP_ANDI = 'd11
) (
  input  logic                   clock,
  input  logic                   reset,
  alu_issue_writeback_if.slave   instr,
  output logic [OPCODE_SIZE-1:0] alu_opcode,
  output logic [WORD_SIZE-1:0]   alu_input1,
  output logic [WORD_SIZE-1:0]   alu_input2,
  output logic                   alu_enable,
  input  logic [WORD_SIZE-1:0]   alu_out,
  output logic                   wb_valid,
  output logic [REG_ADDR-1:0]    wb_addr,
  output logic [WORD_SIZE-1:0]   wb_data,
  output logic [15:0]            retired_count,
  input  logic [REG_ADDR-1:0]    dbg_addr,
  output logic [WORD_SIZE-1:0]   dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

  state_t                                state_q, state_d;
  logic [NUM_REGS-1:0][WORD_SIZE-1:0]    rf_q, rf_d;
  logic [OPCODE_SIZE-1:0]                alu_opcode_q, alu_opcode_d;
  logic [WORD_SIZE-1:0]                  alu_input1_q, alu_input1_d;
  logic [WORD_SIZE-1:0]                  alu_input2_q, alu_input2_d;
  logic                                  alu_enable_q, alu_enable_d;
  logic [REG_ADDR-1:0]                   rd_q, rd_d;
  logic [15:0]                           retired_count_q, retired_count_d;

  logic                 ready;
  logic                 accept;
  logic [WORD_SIZE-1:0] rs1_val, rs2_val, imm_sext, imm_zext;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready    = (state_q == S_IDLE) && !reset;
    accept   = instr.instr_valid && ready;
    wb_valid = (state_q == S_WB);
  end

  assign instr.instr_ready = ready;

  // Operand fetch; r0 is forced to zero on every read path.
  always_comb begin
    rs1_val  = (instr.instr_rs1 == '0) ? '0 : rf_q[instr.instr_rs1];
    rs2_val  = (instr.instr_rs2 == '0) ? '0 : rf_q[instr.instr_rs2];
    imm_sext = {{(WORD_SIZE-IMM_SIZE){instr.instr_imm[IMM_SIZE-1]}}, instr.instr_imm};
    imm_zext = {{(WORD_SIZE-IMM_SIZE){1'b0}}, instr.instr_imm};
  end

  // Issue registers and write-back. Because the stage is non-pipelined the
  // previous write has always landed before the next operand read.
  always_comb begin
    alu_opcode_d    = alu_opcode_q;
    alu_input1_d    = alu_input1_q;
    alu_input2_d    = alu_input2_q;
    rd_d            = rd_q;
    alu_enable_d    = accept;
    rf_d            = rf_q;
    retired_count_d = retired_count_q;
    if (accept) begin
      alu_opcode_d = instr.instr_opcode;
      alu_input1_d = rs1_val;
      rd_d         = instr.instr_rd;
      if (instr.instr_opcode == OP_ADDI)      alu_input2_d = imm_sext;
      else if (instr.instr_opcode == OP_ANDI) alu_input2_d = imm_zext;
      else                                    alu_input2_d = rs2_val;
    end
    if (wb_valid) begin
      if (rd_q != '0) rf_d[rd_q] = alu_out;
      retired_count_d = retired_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_q            <= '0;
      alu_opcode_q    <= '0;
      alu_input1_q    <= '0;
      alu_input2_q    <= '0;
      alu_enable_q    <= 1'b0;
      rd_q            <= '0;
      retired_count_q <= '0;
    end else begin
      rf_q            <= rf_d;
      alu_opcode_q    <= alu_opcode_d;
      alu_input1_q    <= alu_input1_d;
      alu_input2_q    <= alu_input2_d;
      alu_enable_q    <= alu_enable_d;
      rd_q            <= rd_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign alu_opcode    = alu_opcode_q;
  assign alu_input1    = alu_input1_q;
  assign alu_input2    = alu_input2_q;
  assign alu_enable    = alu_enable_q;
  assign wb_addr       = rd_q;
  assign wb_data       = alu_out;
  assign retired_count = retired_count_q;
  assign dbg_data      = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_writeback.sv
// Directed bench for alu_issue_writeback with a small registered alu model.
module tb_alu_issue_writeback;
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_ADDI = 5'd10;
  localparam logic [4:0] OP_ANDI = 5'd11;
  localparam logic [4:0] OP_BAD  = 5'd31;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_input1, alu_input2, alu_out, wb_data, dbg_data;
  logic        alu_enable, wb_valid;
  logic [2:0]  wb_addr, dbg_addr;
  logic [15:0] retired_count;

  int total = 0;
  int bad   = 0;

  alu_issue_writeback_if #(.OPCODE_SIZE(5), .REG_ADDR(3), .IMM_SIZE(8)) ifc ();

  alu_issue_writeback #(.OP_ADDI(OP_ADDI), .OP_ANDI(OP_ANDI)) dut (
    .clock(clock), .reset(reset), .instr(ifc),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_enable(alu_enable), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .retired_count(retired_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  // registered alu: samples on the edge closing the alu_enable cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) alu_out <= '0;
    else if (alu_enable) begin
      case (alu_opcode)
        OP_ADD, OP_ADDI: alu_out <= alu_input1 + alu_input2;
        OP_SUB:          alu_out <= alu_input1 - alu_input2;
        OP_AND, OP_ANDI: alu_out <= alu_input1 & alu_input2;
        default:         alu_out <= '0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic dbg_chk(input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1 chk($sformatf("dbg r%0d", a), dbg_data, exp);
  endtask

  // one full instruction: accept, ISSUE, WB, post-WB register check
  task automatic run(input logic [4:0] op, input logic [2:0] rd, rs1, rs2,
                     input logic [7:0] imm, input logic [15:0] in1, in2, res);
    @(negedge clock);
    chk("ready idle", ifc.instr_ready, 1);
    ifc.instr_valid = 1'b1; ifc.instr_opcode = op; ifc.instr_rd = rd;
    ifc.instr_rs1 = rs1; ifc.instr_rs2 = rs2; ifc.instr_imm = imm;
    @(posedge clock); #1 ifc.instr_valid = 1'b0;
    @(negedge clock);
    chk("issue en", alu_enable, 1);
    chk("issue ready", ifc.instr_ready, 0);
    chk("issue op", alu_opcode, op);
    chk("issue in1", alu_input1, in1);
    chk("issue in2", alu_input2, in2);
    chk("issue wbv", wb_valid, 0);
    @(negedge clock);
    chk("wb en", alu_enable, 0);
    chk("wb valid", wb_valid, 1);
    chk("wb addr", wb_addr, rd);
    chk("wb data", wb_data, res);
    @(negedge clock);
    chk("post wbv", wb_valid, 0);
    dbg_chk(rd, (rd == 3'd0) ? 16'h0 : res);
  endtask

  logic [4:0] q_op  [4];
  logic [2:0] q_rd  [4], q_rs1 [4], q_rs2 [4];
  logic [7:0] q_imm [4];
  int acc [4];

  initial begin
    int q, en_cnt, rdy_cnt;
    ifc.instr_valid = 1'b0; ifc.instr_opcode = '0; ifc.instr_rd = '0;
    ifc.instr_rs1 = '0; ifc.instr_rs2 = '0; ifc.instr_imm = '0; dbg_addr = '0;

    // reset state
    @(negedge clock);
    chk("rst ready", ifc.instr_ready, 0);
    chk("rst en", alu_enable, 0);
    chk("rst wbv", wb_valid, 0);
    chk("rst wbaddr", wb_addr, 0);
    chk("rst count", retired_count, 0);
    chk("rst in1", alu_input1, 0);
    reset = 1'b0;
    #1 chk("ready after rst", ifc.instr_ready, 1);

    run(OP_ADDI, 3'd1, 3'd0, 3'd7, 8'h05, 16'h0000, 16'h0005, 16'h0005);
    run(OP_ADDI, 3'd2, 3'd0, 3'd7, 8'hFD, 16'h0000, 16'hFFFD, 16'hFFFD);
    run(OP_SUB,  3'd3, 3'd1, 3'd2, 8'h00, 16'h0005, 16'hFFFD, 16'h0008);
    chk("count 3", retired_count, 3);
    run(OP_ANDI, 3'd4, 3'd2, 3'd0, 8'hF0, 16'hFFFD, 16'h00F0, 16'h00F0);
    run(OP_ADDI, 3'd0, 3'd1, 3'd0, 8'h01, 16'h0005, 16'h0001, 16'h0006);
    chk("count r0", retired_count, 5);
    // rs==rd reads the old value
    run(OP_ADD,  3'd1, 3'd1, 3'd1, 8'h00, 16'h0005, 16'h0005, 16'h000A);
    // unknown opcode passes through, result 0 overwrites r3
    run(OP_BAD,  3'd3, 3'd1, 3'd2, 8'h00, 16'h000A, 16'hFFFD, 16'h0000);
    chk("count 7", retired_count, 7);

    // back-to-back with valid held high
    q_op[0] = OP_ADDI; q_rd[0] = 3'd5; q_rs1[0] = 3'd0; q_rs2[0] = 3'd0; q_imm[0] = 8'h01;
    q_op[1] = OP_ADDI; q_rd[1] = 3'd6; q_rs1[1] = 3'd0; q_rs2[1] = 3'd0; q_imm[1] = 8'h02;
    q_op[2] = OP_ADD;  q_rd[2] = 3'd7; q_rs1[2] = 3'd5; q_rs2[2] = 3'd6; q_imm[2] = 8'h00;
    q_op[3] = OP_ADDI; q_rd[3] = 3'd5; q_rs1[3] = 3'd5; q_rs2[3] = 3'd0; q_imm[3] = 8'hFF;
    q = 0; en_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clock);
      if (alu_enable) en_cnt++;
      if (c < 10 && ifc.instr_ready) rdy_cnt++;
      if (q < 4) begin
        ifc.instr_valid = 1'b1; ifc.instr_opcode = q_op[q]; ifc.instr_rd = q_rd[q];
        ifc.instr_rs1 = q_rs1[q]; ifc.instr_rs2 = q_rs2[q]; ifc.instr_imm = q_imm[q];
        if (ifc.instr_ready) begin acc[q] = c; q++; end
      end else ifc.instr_valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) chk($sformatf("accept edge %0d", k), acc[k], 3 * k);
    chk("enable cycles", en_cnt, 4);
    chk("ready cycles", rdy_cnt, 4);
    dbg_chk(3'd7, 16'h0003);
    dbg_chk(3'd5, 16'h0000);
    dbg_chk(3'd6, 16'h0002);
    chk("count 11", retired_count, 11);

    // reset in the middle of ISSUE
    @(negedge clock);
    ifc.instr_valid = 1'b1; ifc.instr_opcode = OP_ADDI; ifc.instr_rd = 3'd5;
    ifc.instr_rs1 = 3'd0; ifc.instr_rs2 = 3'd0; ifc.instr_imm = 8'h07;
    @(posedge clock); #1 ifc.instr_valid = 1'b0;
    @(negedge clock);
    chk("pre-rst en", alu_enable, 1);
    #1 reset = 1'b1;
    #1 chk("rst en drop", alu_enable, 0);
    chk("rst ready low", ifc.instr_ready, 0);
    chk("rst count clr", retired_count, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst no wbv", wb_valid, 0);
    end
    reset = 1'b0;
    #1 chk("ready release", ifc.instr_ready, 1);
    dbg_chk(3'd5, 16'h0000);
    dbg_chk(3'd1, 16'h0000);
    dbg_chk(3'd4, 16'h0000);
    dbg_chk(3'd7, 16'h0000);
    @(negedge clock);
    chk("idle wbv", wb_valid, 0);
    chk("count after rst", retired_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
